sprite_loc_ctrl: RTL and testbench
==================================

Name: sprite_loc_ctrl

Overview:
Parametrised successor to the single-step player location controller. Tracks one sprite (pacman or ghost) on a tile map, buffers the requested turn, and advances one tile per move tick. Legality is checked through a request/valid tile-query port to the map RAM. The position commits only after the RAM writer acknowledges the redraw, with optional tunnel wrap-around at the map edges.

Parameters:
X_W, 6, tile x coordinate width
Y_W, 5, tile y coordinate width
MAP_W, 40, map width in tiles; legal x is 0..MAP_W-1
MAP_H, 30, map height in tiles; legal y is 0..MAP_H-1
START_X, 20, reset x
START_Y, 20, reset y
WRAP_EN, 1, 1 = edge moves wrap to the opposite edge; 0 = edge is treated as a wall
MOVE_DIV, 2500000, CLOCK_50 cycles per move tick (>=2)
CNT_W, 22, tick counter width (holds MOVE_DIV-1)

Ports:
CLOCK_50  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  0 freezes the tick counter; no new moves start
up, down, left, right  in  1 each  direction request; fixed priority up>down>left>right
tile_req  out  1  map query request, held until tile_valid
tile_x  out  X_W  queried tile x
tile_y  out  Y_W  queried tile y
tile_valid  in  1  query response strobe
tile_wall  in  1  queried tile is wall; sampled with tile_valid
wr_req  out  1  redraw request, held until wr_done
wr_done  in  1  RAM writer finished erasing curr and drawing next
curr_x  out  X_W  committed position x
curr_y  out  Y_W  committed position y
next_x  out  X_W  target position x
next_y  out  Y_W  target position y
cur_dir  out  2  00 up, 01 down, 10 left, 11 right
moving  out  1  cur_dir is active
step_count  out  16  committed moves; wraps at 2^16

Behaviour:
- Reset values: curr = next = (START_X, START_Y); cur_dir = 00; moving = 0; pend_valid = 0; tick counter = 0; tile_req = 0; wr_req = 0; step_count = 0; FSM state IDLE.
- Pending turn:
  - Any direction input high on a clock edge loads pend_dir (priority-encoded) and sets pend_valid.
  - The latest request overwrites the previous one.
  - Releasing the inputs does not clear pend_valid.
- Tick counter:
  - Counts 0..MOVE_DIV-1 while enable=1, then wraps; tick = 1 on the wrap cycle.
  - A tick that arrives while the FSM is not in IDLE is dropped, not queued.
- Target computation: target = curr offset by ±1 in the chosen direction.
  - x=0 moving left -> MAP_W-1; x=MAP_W-1 moving right -> 0; same rule for y with MAP_H. Applies only when WRAP_EN=1.
  - With WRAP_EN=0 an edge step is an immediate wall: no query is issued, zero extra cycles.
- FSM:
  - IDLE: on tick:
    - pend_valid -> QRY_P with target from pend_dir.
    - else moving -> QRY_C with target from cur_dir.
    - else stay in IDLE.
  - QRY_P: tile_req=1, tile_x/y = target.
    - On tile_valid & !tile_wall: cur_dir <= pend_dir, moving <= 1, pend_valid <= 0, next <= target -> COMMIT.
    - On tile_valid & tile_wall: if moving -> QRY_C; else pend_valid stays set -> IDLE.
  - QRY_C: tile_req=1.
    - On tile_valid & !tile_wall: next <= target -> COMMIT.
    - On wall: moving <= 0, next <= curr -> IDLE.
  - COMMIT: wr_req=1 (next already stable). On wr_done: curr <= next, step_count += 1 -> IDLE.
- Handshakes:
  - tile_req drops the cycle after tile_valid; tile_x/y stay stable while tile_req=1.
  - tile_valid or wr_done arriving outside its state is ignored.
  - Minimum latency tick -> curr update is 3 cycles (query response and wr_done each returned in 1 cycle).
- enable=0 mid-move: the in-flight query/commit completes; only new ticks are suppressed.
- Reset mid-operation: immediate return to reset values; outstanding tile_valid/wr_done is ignored.
- The turn buffer and the tick may update on the same edge: the tick uses the pre-edge pend_dir.

Test Plan:
- MOVE_DIV=4, reset, right pulse 1 cycle, no walls, 1-cycle responses -> tile_req at (21,20); curr=(21,20) after wr_done; cur_dir=11, moving=1, step_count=1.
- Continue with no input -> one tile per tick: curr=(22,20), then (23,20); no tick requested while in COMMIT.
- moving right, pend up, tile (23,19) wall -> fallback query (24,20), curr=(24,20), pend_valid still 1; when (24,19) is free, next tick turns up to (24,19).
- curr=(39,10) moving right, WRAP_EN=1 -> query (0,10), curr=(0,10). WRAP_EN=0 -> no tile_req, moving=0, curr stays (39,10).
- Wall ahead with no pending turn -> moving=0, next=curr, no wr_req. Later ticks issue no queries until a new direction arrives.
- Assert reset while wr_req is high, then pulse wr_done -> curr=(20,20), wr_req=0, step_count=0, no update.

Source files
------------

// File: rtl/sprite_loc_ctrl_if.sv
// Tile-query and redraw handshake bundle between the sprite controller
// (master) and the map RAM / RAM writer (slave).
interface sprite_loc_ctrl_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5
) ();
  logic           tile_req;
  logic [X_W-1:0] tile_x;
  logic [Y_W-1:0] tile_y;
  logic           tile_valid;
  logic           tile_wall;
  logic           wr_req;
  logic           wr_done;

  modport master (
    output tile_req, tile_x, tile_y, wr_req,
    input  tile_valid, tile_wall, wr_done
  );

  modport slave (
    input  tile_req, tile_x, tile_y, wr_req,
    output tile_valid, tile_wall, wr_done
  );
endinterface

// File: rtl/sprite_loc_ctrl.sv
// Tile-map sprite location controller: buffered turns, move ticks, legality
// query to the map RAM and redraw-acknowledged position commit.
module sprite_loc_ctrl #(
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAP_W    = 40,
  parameter int MAP_H    = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 20,
  parameter int WRAP_EN  = 1,
  parameter int MOVE_DIV = 2500000,
  parameter int CNT_W    = 22
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  sprite_loc_ctrl_if.master  bus,
  output logic [X_W-1:0]     curr_x,
  output logic [Y_W-1:0]     curr_y,
  output logic [X_W-1:0]     next_x,
  output logic [Y_W-1:0]     next_y,
  output logic [1:0]         cur_dir,
  output logic               moving,
  output logic [15:0]        step_count
);

  typedef enum logic [1:0] {IDLE, QRY_P, QRY_C, COMMIT} state_t;

  typedef struct packed {
    logic           blk;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } tgt_t;

  // Neighbour tile in direction dir; blk flags an edge step with wrap disabled.
  function automatic tgt_t step_to(input logic [1:0] dir, input logic [X_W-1:0] x,
                                   input logic [Y_W-1:0] y);
    tgt_t t;
    t.blk = 1'b0;
    t.x   = x;
    t.y   = y;
    case (dir)
      2'b00: if (y == '0) begin
               if (WRAP_EN != 0) t.y = Y_W'(MAP_H - 1); else t.blk = 1'b1;
             end else t.y = y - 1'b1;
      2'b01: if (y == Y_W'(MAP_H - 1)) begin
               if (WRAP_EN != 0) t.y = '0; else t.blk = 1'b1;
             end else t.y = y + 1'b1;
      2'b10: if (x == '0) begin
               if (WRAP_EN != 0) t.x = X_W'(MAP_W - 1); else t.blk = 1'b1;
             end else t.x = x - 1'b1;
      default: if (x == X_W'(MAP_W - 1)) begin
               if (WRAP_EN != 0) t.x = '0; else t.blk = 1'b1;
             end else t.x = x + 1'b1;
    endcase
    return t;
  endfunction

  state_t         state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           tick;
  logic [1:0]     pend_dir_q, qry_dir_q, cur_dir_q, req_dir;
  logic           pend_valid_q, moving_q, req_any;
  logic [X_W-1:0] curr_x_q, next_x_q, tile_x_q;
  logic [Y_W-1:0] curr_y_q, next_y_q, tile_y_q;
  logic           tile_req_q, wr_req_q;
  logic [15:0]    step_q;
  tgt_t           pend_tgt, cur_tgt;
  logic           want_cur;

  assign tick     = enable && (cnt_q == CNT_W'(MOVE_DIV - 1));
  assign req_any  = up | down | left | right;
  assign req_dir  = up ? 2'd0 : down ? 2'd1 : left ? 2'd2 : 2'd3;
  assign pend_tgt = step_to(pend_dir_q, curr_x_q, curr_y_q);
  assign cur_tgt  = step_to(cur_dir_q, curr_x_q, curr_y_q);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Continue straight ahead: tick with no usable turn, or turn rejected while moving.
  always_comb begin
    want_cur = 1'b0;
    case (state_q)
      IDLE:    want_cur = tick && moving_q && (!pend_valid_q || pend_tgt.blk);
      QRY_P:   want_cur = tile_req_q && bus.tile_valid && bus.tile_wall && moving_q;
      default: want_cur = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_dir_q   <= 2'd0;
      qry_dir_q    <= 2'd0;
      cur_dir_q    <= 2'd0;
      pend_valid_q <= 1'b0;
      moving_q     <= 1'b0;
      curr_x_q     <= X_W'(START_X);
      curr_y_q     <= Y_W'(START_Y);
      next_x_q     <= X_W'(START_X);
      next_y_q     <= Y_W'(START_Y);
      tile_x_q     <= X_W'(START_X);
      tile_y_q     <= Y_W'(START_Y);
      tile_req_q   <= 1'b0;
      wr_req_q     <= 1'b0;
      step_q       <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (tick && pend_valid_q && !pend_tgt.blk) begin
          tile_x_q   <= pend_tgt.x;
          tile_y_q   <= pend_tgt.y;
          qry_dir_q  <= pend_dir_q;
          tile_req_q <= 1'b1;
          state_q    <= QRY_P;
        end
        QRY_P: if (bus.tile_valid) begin
          tile_req_q <= 1'b0;
          if (!bus.tile_wall) begin
            cur_dir_q    <= qry_dir_q;
            moving_q     <= 1'b1;
            pend_valid_q <= 1'b0;
            next_x_q     <= tile_x_q;
            next_y_q     <= tile_y_q;
            wr_req_q     <= 1'b1;
            state_q      <= COMMIT;
          end else begin
            state_q <= IDLE;
          end
        end
        // Entered from QRY_P with tile_req low for one cycle so the request
        // visibly drops after each response before the fallback query.
        QRY_C: if (!tile_req_q) begin
          tile_req_q <= 1'b1;
        end else if (bus.tile_valid) begin
          tile_req_q <= 1'b0;
          if (!bus.tile_wall) begin
            next_x_q <= tile_x_q;
            next_y_q <= tile_y_q;
            wr_req_q <= 1'b1;
            state_q  <= COMMIT;
          end else begin
            moving_q <= 1'b0;
            next_x_q <= curr_x_q;
            next_y_q <= curr_y_q;
            state_q  <= IDLE;
          end
        end
        COMMIT: if (bus.wr_done) begin
          curr_x_q <= next_x_q;
          curr_y_q <= next_y_q;
          step_q   <= step_q + 16'd1;
          wr_req_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Straight-ahead step overrides the case above; an edge wall resolves at once.
      if (want_cur) begin
        if (cur_tgt.blk) begin
          moving_q <= 1'b0;
          next_x_q <= curr_x_q;
          next_y_q <= curr_y_q;
          state_q  <= IDLE;
        end else begin
          tile_x_q   <= cur_tgt.x;
          tile_y_q   <= cur_tgt.y;
          tile_req_q <= (state_q == IDLE);
          state_q    <= QRY_C;
        end
      end
      if (req_any) begin
        pend_dir_q   <= req_dir;
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign bus.tile_req = tile_req_q;
  assign bus.tile_x   = tile_x_q;
  assign bus.tile_y   = tile_y_q;
  assign bus.wr_req   = wr_req_q;
  assign curr_x       = curr_x_q;
  assign curr_y       = curr_y_q;
  assign next_x       = next_x_q;
  assign next_y       = next_y_q;
  assign cur_dir      = cur_dir_q;
  assign moving       = moving_q;
  assign step_count   = step_q;

endmodule

// File: tb/tb_sprite_loc_ctrl.sv
// Self-checking bench for sprite_loc_ctrl: directed vector table, wrap and
// reset sequences, and random moves against a tile-level reference model.
module tb_sprite_loc_ctrl;
  localparam int X_W = 6, Y_W = 5, MAP_W = 40, MAP_H = 30, MD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, enable = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [X_W-1:0] curr_x, next_x;
  logic [Y_W-1:0] curr_y, next_y;
  logic [1:0]     cur_dir;
  logic           moving;
  logic [15:0]    step_count;

  logic en2 = 1'b0, right2 = 1'b0;
  logic [X_W-1:0] curr_x2, next_x2;
  logic [Y_W-1:0] curr_y2, next_y2;
  logic [1:0]     cur_dir2;
  logic           moving2;
  logic [15:0]    step_count2;

  sprite_loc_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) bus ();
  sprite_loc_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) bus2 ();

  sprite_loc_ctrl #(.X_W(X_W), .Y_W(Y_W), .MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(20),
                    .START_Y(20), .WRAP_EN(1), .MOVE_DIV(MD), .CNT_W(3)) u_dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .up(up), .down(down), .left(left),
    .right(right), .bus(bus), .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x),
    .next_y(next_y), .cur_dir(cur_dir), .moving(moving), .step_count(step_count));

  sprite_loc_ctrl #(.X_W(X_W), .Y_W(Y_W), .MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(38),
                    .START_Y(10), .WRAP_EN(0), .MOVE_DIV(MD), .CNT_W(3)) u_dut_nowrap (
    .CLOCK_50(clk), .reset(reset), .enable(en2), .up(1'b0), .down(1'b0), .left(1'b0),
    .right(right2), .bus(bus2), .curr_x(curr_x2), .curr_y(curr_y2), .next_x(next_x2),
    .next_y(next_y2), .cur_dir(cur_dir2), .moving(moving2), .step_count(step_count2));

  int checks = 0, failures = 0;
  bit wall_map [MAP_W][MAP_H];
  int rsp_lat_max = 0;
  int q_cnt = 0, w_cnt = 0, lq_x = 0, lq_y = 0, q2_cnt = 0;
  bit wr_hold = 1'b0, wr_kick = 1'b0;

  // Reference model state (tile-level rules only)
  int m_x, m_y, m_dir, m_pend_dir, m_steps;
  bit m_mov, m_pend;

  typedef struct {
    int d; int nq; int qx; int qy; int cx; int cy; int dir; int mv; int st; int nw;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Map RAM and RAM writer for the wrapping DUT, with random response delays.
  initial begin : rsp1
    int wq, lq, ww, lw;
    wq = 0; lq = 0; ww = 0; lw = 0;
    bus.tile_valid = 1'b0; bus.tile_wall = 1'b0; bus.wr_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      bus.tile_valid = 1'b0; bus.tile_wall = 1'b0; bus.wr_done = 1'b0;
      if (bus.tile_req) begin
        if (wq >= lq) begin
          lq_x = int'(bus.tile_x);
          lq_y = int'(bus.tile_y);
          bus.tile_valid = 1'b1;
          bus.tile_wall = (lq_x < MAP_W && lq_y < MAP_H) ? wall_map[lq_x][lq_y] : 1'b1;
          q_cnt++; wq = 0; lq = int'($urandom_range(0, rsp_lat_max));
        end else wq++;
      end else wq = 0;
      if (wr_hold) bus.wr_done = wr_kick;
      else if (bus.wr_req) begin
        if (ww >= lw) begin
          bus.wr_done = 1'b1; w_cnt++; ww = 0; lw = int'($urandom_range(0, rsp_lat_max));
        end else ww++;
      end else ww = 0;
    end
  end

  initial begin : rsp2
    bus2.tile_valid = 1'b0; bus2.tile_wall = 1'b0; bus2.wr_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      bus2.tile_valid = bus2.tile_req;
      bus2.wr_done = bus2.wr_req;
      if (bus2.tile_req) q2_cnt++;
    end
  end

  task automatic model_reset();
    m_x = 20; m_y = 20; m_dir = 0; m_pend_dir = 0; m_steps = 0; m_mov = 0; m_pend = 0;
  endtask

  task automatic nb(input int x, input int y, input int d, output int nx, output int ny);
    nx = x; ny = y;
    case (d)
      0: ny = (y + MAP_H - 1) % MAP_H;
      1: ny = (y + 1) % MAP_H;
      2: nx = (x + MAP_W - 1) % MAP_W;
      default: nx = (x + 1) % MAP_W;
    endcase
  endtask

  // One move tick: try the buffered turn, else keep going straight.
  task automatic model_round(input int d, output int enq, output int enw);
    int nx, ny;
    enq = 0; enw = 0;
    if (d < 4) begin m_pend = 1; m_pend_dir = d; end
    if (m_pend) begin
      nb(m_x, m_y, m_pend_dir, nx, ny);
      enq = 1;
      if (!wall_map[nx][ny]) begin
        m_x = nx; m_y = ny; m_dir = m_pend_dir; m_mov = 1; m_pend = 0;
        m_steps = (m_steps + 1) % 65536; enw = 1;
        return;
      end
    end
    if (m_mov) begin
      nb(m_x, m_y, m_dir, nx, ny);
      enq++;
      if (!wall_map[nx][ny]) begin
        m_x = nx; m_y = ny; m_steps = (m_steps + 1) % 65536; enw = 1;
      end else m_mov = 0;
    end
  endtask

  // Optional direction pulse with the counter frozen, then let exactly one tick through.
  task automatic do_round(input int d, output int nq, output int nw, output bit timeout);
    int q0, w0, idle_n;
    bit seen;
    q0 = q_cnt; w0 = w_cnt; timeout = 0; seen = 0; idle_n = 0;
    @(negedge clk);
    if (d < 4) begin
      up = (d == 0); down = (d == 1); left = (d == 2); right = (d == 3);
      @(negedge clk);
      up = 0; down = 0; left = 0; right = 0;
    end
    enable = 1'b1;
    for (int i = 0; i < 3 * MD + 2 && !seen; i++) begin
      @(negedge clk);
      if (bus.tile_req) seen = 1;
    end
    enable = 1'b0;
    if (seen) begin
      for (int i = 0; i < 100 && idle_n < 2; i++) begin
        @(negedge clk);
        if (!bus.tile_req && !bus.wr_req) idle_n++; else idle_n = 0;
      end
      if (idle_n < 2) timeout = 1;
    end
    #2;
    nq = q_cnt - q0; nw = w_cnt - w0;
  endtask

  task automatic chk_pos(input string tag, input int cx, input int cy);
    chk({tag, "_curr_x"}, 32'(curr_x), cx);
    chk({tag, "_curr_y"}, 32'(curr_y), cy);
    chk({tag, "_next_x"}, 32'(next_x), cx);
    chk({tag, "_next_y"}, 32'(next_y), cy);
  endtask

  initial begin : main
    int nq, nw, enq, enw, n2, d;
    bit to, reached;

    tbl[0] = '{3, 1, 21, 20, 21, 20, 3, 1, 1, 1};
    tbl[1] = '{4, 1, 22, 20, 22, 20, 3, 1, 2, 1};
    tbl[2] = '{4, 1, 23, 20, 23, 20, 3, 1, 3, 1};
    tbl[3] = '{0, 2, 24, 20, 24, 20, 3, 1, 4, 1};
    tbl[4] = '{4, 1, 24, 19, 24, 19, 0, 1, 5, 1};
    tbl[5] = '{4, 1, 24, 18, 24, 19, 0, 0, 5, 0};
    tbl[6] = '{4, 0, 0, 0, 24, 19, 0, 0, 5, 0};
    wall_map[23][19] = 1'b1;
    wall_map[24][18] = 1'b1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_pos("rst", 20, 20);
    chk("rst_dir", 32'(cur_dir), 0);
    chk("rst_moving", 32'(moving), 0);
    chk("rst_tile_req", 32'(bus.tile_req), 0);
    chk("rst_wr_req", 32'(bus.wr_req), 0);
    chk("rst_steps", 32'(step_count), 0);
    chk("rst2_curr_x", 32'(curr_x2), 38);
    model_reset();

    // Edge as wall: one step to x=39, then the edge step stops with no query.
    right2 = 1'b1; @(negedge clk); right2 = 1'b0; en2 = 1'b1;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(negedge clk);
      if (curr_x2 == 6'd39) reached = 1;
    end
    chk("nowrap_reach39", 32'(reached), 1);
    n2 = 0;
    for (int i = 0; i < 3 * MD + 4; i++) begin
      @(negedge clk);
      if (bus2.tile_req) n2++;
    end
    en2 = 1'b0;
    chk("nowrap_edge_queries", n2, 0);
    chk("nowrap_total_queries", q2_cnt, 1);
    chk("nowrap_moving", 32'(moving2), 0);
    chk("nowrap_curr_x", 32'(curr_x2), 39);
    chk("nowrap_curr_y", 32'(curr_y2), 10);
    chk("nowrap_next_x", 32'(next_x2), 39);
    chk("nowrap_steps", 32'(step_count2), 1);
    $display("nowrap: curr=(%0d,%0d) moving=%0d steps=%0d", curr_x2, curr_y2, moving2, step_count2);

    for (int i = 0; i < 7; i++) begin
      do_round(tbl[i].d, nq, nw, to);
      model_round(tbl[i].d, enq, enw);
      $display("vec %0d: in=%0d q=%0d last=(%0d,%0d) curr=(%0d,%0d) dir=%0d mv=%0d steps=%0d",
               i, tbl[i].d, nq, lq_x, lq_y, curr_x, curr_y, cur_dir, moving, step_count);
      chk($sformatf("vec%0d_done", i), 32'(to), 0);
      chk($sformatf("vec%0d_nq", i), nq, tbl[i].nq);
      if (tbl[i].nq > 0) begin
        chk($sformatf("vec%0d_qx", i), lq_x, tbl[i].qx);
        chk($sformatf("vec%0d_qy", i), lq_y, tbl[i].qy);
      end
      chk_pos($sformatf("vec%0d", i), tbl[i].cx, tbl[i].cy);
      chk($sformatf("vec%0d_dir", i), 32'(cur_dir), tbl[i].dir);
      chk($sformatf("vec%0d_mv", i), 32'(moving), tbl[i].mv);
      chk($sformatf("vec%0d_steps", i), 32'(step_count), tbl[i].st);
      chk($sformatf("vec%0d_nw", i), nw, tbl[i].nw);
    end

    // Run right along row 19 through x=39 and wrap to x=0.
    for (int k = 0; k < 16; k++) begin
      d = (k == 0) ? 3 : 4;
      do_round(d, nq, nw, to);
      model_round(d, enq, enw);
      $display("wrap %0d: q=(%0d,%0d) curr=(%0d,%0d) steps=%0d", k, lq_x, lq_y, curr_x, curr_y, step_count);
      chk($sformatf("wrap%0d_curr_x", k), 32'(curr_x), m_x);
    end
    chk("wrap_query_x", lq_x, 0);
    chk("wrap_query_y", lq_y, 19);
    chk_pos("wrap", 0, 19);
    chk("wrap_steps", 32'(step_count), 21);

    // Reset while a redraw is outstanding; the late wr_done must be ignored.
    wr_hold = 1'b1; wr_kick = 1'b0;
    enable = 1'b1;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(negedge clk);
      if (bus.wr_req) reached = 1;
    end
    enable = 1'b0;
    chk("midrst_wr_req_seen", 32'(reached), 1);
    reset = 1'b1; wr_kick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr_kick = 1'b0;
    @(negedge clk);
    wr_hold = 1'b0;
    $display("midrst: curr=(%0d,%0d) wr_req=%0d steps=%0d", curr_x, curr_y, bus.wr_req, step_count);
    chk_pos("midrst", 20, 20);
    chk("midrst_wr_req", 32'(bus.wr_req), 0);
    chk("midrst_steps", 32'(step_count), 0);
    chk("midrst_moving", 32'(moving), 0);

    // Random walls, random turns, random response latency.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    for (int x = 0; x < MAP_W; x++)
      for (int y = 0; y < MAP_H; y++)
        wall_map[x][y] = ($urandom_range(0, 3) == 0);
    rsp_lat_max = 3;
    for (int r = 0; r < 40; r++) begin
      d = int'($urandom_range(0, 5));
      if (d > 3) d = 4;
      do_round(d, nq, nw, to);
      model_round(d, enq, enw);
      $display("rand %0d: in=%0d q=%0d w=%0d curr=(%0d,%0d) dir=%0d mv=%0d steps=%0d",
               r, d, nq, nw, curr_x, curr_y, cur_dir, moving, step_count);
      chk($sformatf("rand%0d_done", r), 32'(to), 0);
      chk($sformatf("rand%0d_nq", r), nq, enq);
      chk($sformatf("rand%0d_nw", r), nw, enw);
      chk_pos($sformatf("rand%0d", r), m_x, m_y);
      chk($sformatf("rand%0d_dir", r), 32'(cur_dir), m_dir);
      chk($sformatf("rand%0d_mv", r), 32'(moving), 32'(m_mov));
      chk($sformatf("rand%0d_steps", r), 32'(step_count), m_steps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
